// File: rtl/lock_ctrl.sv
// Keypad combination lock: passcode entry in SET, eight-digit unlock attempts,
// OPEN on a match, ALARM after three failed attempts.
module lock_ctrl (
    input  logic        hz100,
    input  logic        reset,
    input  logic        keydown,
    input  logic [3:0]  keycode,
    output logic [3:0]  state,
    output logic [31:0] seq,
    output logic [1:0]  attempts
);

    typedef enum logic [3:0] {
        LS0   = 4'd0,
        LS1   = 4'd1,
        LS2   = 4'd2,
        LS3   = 4'd3,
        LS4   = 4'd4,
        LS5   = 4'd5,
        LS6   = 4'd6,
        LS7   = 4'd7,
        OPEN  = 4'd8,
        ALARM = 4'd9,
        SET   = 4'd10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] pass_q, pass_d;
    logic [3:0]  count_q, count_d;
    logic        mism_q, mism_d;
    logic [1:0]  att_q, att_d;
    logic        kd_q, kd_d;

    logic        key_ev;
    logic        is_digit;
    logic        is_clear;
    logic        is_lock;
    logic [4:0]  sh;
    logic [3:0]  nib;
    logic        miss;

    assign key_ev   = keydown & ~kd_q;
    assign is_digit = keycode < 4'd10;
    assign is_clear = keycode == 4'hE;
    assign is_lock  = keycode == 4'hF;

    // Entry position n checks the n-th digit entered, held in the top nibble first
    assign sh   = 5'd28 - {state_q[2:0], 2'b00};
    assign nib  = pass_q[sh +: 4];
    assign miss = mism_q | (keycode != nib);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        pass_d  = pass_q;
        count_d = count_q;
        mism_d  = mism_q;
        att_d   = att_q;
        kd_d    = keydown;
        if (key_ev) begin
            case (state_q)
                SET: begin
                    if (is_digit && count_q != 4'd8) begin
                        seq_d   = {seq_q[27:0], keycode};
                        count_d = count_q + 4'd1;
                    end else if (is_clear) begin
                        seq_d   = '0;
                        count_d = '0;
                    end else if (is_lock && count_q == 4'd8) begin
                        pass_d  = seq_q;
                        seq_d   = '0;
                        count_d = '0;
                        att_d   = '0;
                        state_d = LS0;
                    end
                end
                OPEN: begin
                    if (is_lock) begin
                        state_d = LS0;
                        mism_d  = 1'b0;
                        att_d   = '0;
                    end
                end
                ALARM: ;
                default: begin
                    if (!state_q[3]) begin
                        if (is_digit) begin
                            if (state_q != LS7) begin
                                mism_d  = miss;
                                state_d = state_t'(state_q + 4'd1);
                            end else if (!miss) begin
                                state_d = OPEN;
                                att_d   = '0;
                            end else if (att_q == 2'd2) begin
                                state_d = ALARM;
                            end else begin
                                att_d   = att_q + 2'd1;
                                mism_d  = 1'b0;
                                state_d = LS0;
                            end
                        end else if (is_clear) begin
                            state_d = LS0;
                            mism_d  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q <= SET;
            seq_q   <= '0;
            pass_q  <= '0;
            count_q <= '0;
            mism_q  <= 1'b0;
            att_q   <= '0;
            kd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            pass_q  <= pass_d;
            count_q <= count_d;
            mism_q  <= mism_d;
            att_q   <= att_d;
            kd_q    <= kd_d;
        end
    end

    assign state    = state_q;
    assign seq      = seq_q;
    assign attempts = att_q;

endmodule
